// File: rtl/timer_irq_pkg.sv
// Shared timer definitions: register offsets, CTRL bits, interrupt ids.
// Also the bus offset decoder used by the timer register file.
package timer_irq_pkg;

  localparam logic [3:0] TIMER_CTRL  = 4'h0;
  localparam logic [3:0] TIMER_COUNT = 4'h4;
  localparam logic [3:0] TIMER_VALUE = 4'h8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;

  localparam logic [7:0]  INT_NONE   = 8'h00;
  localparam logic [7:0]  INT_TIMER0 = 8'h01;
  localparam logic [31:0] ZeroWord   = 32'h0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_COUNT,
    SEL_VALUE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(
    input logic [3:0] off
  );
    reg_sel_e sel;
    case (off)
      TIMER_CTRL:  sel = SEL_CTRL;
      TIMER_COUNT: sel = SEL_COUNT;
      TIMER_VALUE: sel = SEL_VALUE;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_irq_prescaler.sv
// Count-rate divider: one tick every PRESCALE enabled cycles.
// Held at zero whenever counting is disabled.
module timer_irq_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = en && (cnt == LAST);

  // divider counter: wraps on tick, clears while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'h0;
    end else if (!en || tick) begin
      cnt <= 16'h0;
    end else begin
      cnt <= cnt + 16'h1;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped compare timer with sticky, level interrupt flag.
// Flag stays up until software clears PEND or drops IE.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int         PRESCALE = 1,
  parameter logic [7:0] INT_ID   = INT_TIMER0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  int_sig_o
);

  logic        en, ie, pend;
  logic [31:0] count, value;
  logic        en_n, ie_n, pend_n;
  logic [31:0] count_n, value_n;

  logic        tick;
  reg_sel_e    sel;
  logic        wr_ctrl, wr_count, wr_value;
  logic        step, hit, expire;
  logic [27:0] unused_addr;

  assign unused_addr = addr_i[31:4];

  timer_irq_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_psc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign sel      = decode_off(addr_i[3:0]);
  assign wr_ctrl  = we_i && (sel == SEL_CTRL);
  assign wr_count = we_i && (sel == SEL_COUNT);
  assign wr_value = we_i && (sel == SEL_VALUE);

  // compare uses the current VALUE, even if it is being rewritten
  assign step   = tick && (value != ZeroWord);
  assign hit    = (count == value - 32'd1);
  assign expire = step && hit && !wr_count;

  // next-state: bus writes, count step, sticky pending flag
  always_comb begin
    en_n    = en;
    ie_n    = ie;
    pend_n  = pend;
    count_n = count;
    value_n = value;
    if (wr_ctrl) begin
      en_n = data_i[CTRL_EN];
      ie_n = data_i[CTRL_IE];
      if (data_i[CTRL_PEND]) pend_n = 1'b0;
    end
    if (wr_count) begin
      count_n = data_i;
    end else if (step) begin
      count_n = hit ? ZeroWord : count + 32'd1;
    end
    if (expire) pend_n = 1'b1;
    if (wr_value) value_n = data_i;
  end

  // register file and registered interrupt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      pend      <= 1'b0;
      count     <= ZeroWord;
      value     <= ZeroWord;
      int_sig_o <= INT_NONE;
    end else begin
      en        <= en_n;
      ie        <= ie_n;
      pend      <= pend_n;
      count     <= count_n;
      value     <= value_n;
      int_sig_o <= (pend_n && ie_n) ? INT_ID : INT_NONE;
    end
  end

  // combinational read mux
  always_comb begin
    data_o = ZeroWord;
    unique case (1'b1)
      sel == SEL_CTRL:  data_o = {29'h0, pend, ie, en};
      sel == SEL_COUNT: data_o = count;
      sel == SEL_VALUE: data_o = value;
      default:          data_o = ZeroWord;
    endcase
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: vector table plus corner sequences.
// Two instances cover PRESCALE=1 and PRESCALE=4.
module tb_timer_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [7:0]  irq   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_irq #(.PRESCALE(1), .INT_ID(8'h01)) dut1 (
    .clk(clk), .rst(rst), .we_i(we[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .data_o(rdata[0]), .int_sig_o(irq[0])
  );

  timer_irq #(.PRESCALE(4), .INT_ID(8'h01)) dut4 (
    .clk(clk), .rst(rst), .we_i(we[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .data_o(rdata[1]), .int_sig_o(irq[1])
  );

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  ra;
    logic [31:0] rexp;
    logic [7:0]  iexp;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input logic [3:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    we[s]    = 1'b1;
    addr[s]  = 32'h1000_0000 | {28'h0, a};
    wdata[s] = d;
    @(posedge clk);
    #1;
    we[s] = 1'b0;
  endtask

  task automatic rd(input int s, input logic [3:0] a,
                    output logic [31:0] v);
    addr[s] = 32'h1000_0000 | {28'h0, a};
    #1;
    v = rdata[s];
  endtask

  task automatic chk_rd(input int s, input string nm,
                        input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(s, a, v);
    chk(nm, v, exp);
  endtask

  task automatic chk_irq(input int s, input string nm,
                         input logic [7:0] exp);
    chk(nm, {24'h0, irq[s]}, {24'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end

    tv[0]  = '{1'b1, 4'h8, 32'd5,    4'h4, 32'd0,    8'h00};
    tv[1]  = '{1'b1, 4'h0, 32'h3,    4'h4, 32'd0,    8'h00};
    tv[2]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd1,    8'h00};
    tv[3]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd2,    8'h00};
    tv[4]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd3,    8'h00};
    tv[5]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd4,    8'h00};
    tv[6]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd0,    8'h01};
    tv[7]  = '{1'b0, 4'h0, 32'h0,    4'h0, 32'h7,    8'h01};
    tv[8]  = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd2,    8'h01};
    tv[9]  = '{1'b1, 4'h0, 32'h7,    4'h0, 32'h3,    8'h00};
    tv[10] = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd4,    8'h00};
    tv[11] = '{1'b1, 4'h0, 32'h7,    4'h0, 32'h7,    8'h01};
    tv[12] = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd1,    8'h01};
    tv[13] = '{1'b1, 4'h0, 32'h7,    4'h0, 32'h3,    8'h00};
    tv[14] = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd3,    8'h00};
    tv[15] = '{1'b0, 4'h0, 32'h0,    4'h4, 32'd4,    8'h00};
    tv[16] = '{1'b1, 4'h4, 32'h10,   4'h0, 32'h3,    8'h00};
    tv[17] = '{1'b0, 4'h0, 32'h0,    4'h4, 32'h11,   8'h00};
    tv[18] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hC, 32'h0, 8'h00};
    tv[19] = '{1'b1, 4'h4, 32'd4,    4'h4, 32'd4,    8'h00};
    tv[20] = '{1'b1, 4'h8, 32'd7,    4'h4, 32'd0,    8'h01};
    tv[21] = '{1'b0, 4'h0, 32'h0,    4'h8, 32'd7,    8'h01};
    tv[22] = '{1'b1, 4'h0, 32'h1,    4'h0, 32'h5,    8'h00};
    tv[23] = '{1'b1, 4'h0, 32'h3,    4'h0, 32'h7,    8'h01};
    tv[24] = '{1'b1, 4'h0, 32'h0,    4'h4, 32'd4,    8'h00};
    tv[25] = '{1'b0, 4'h0, 32'h0,    4'h0, 32'h4,    8'h00};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk_rd(0, "rst_ctrl",  4'h0, 32'h0);
    chk_rd(0, "rst_count", 4'h4, 32'h0);
    chk_rd(0, "rst_value", 4'h8, 32'h0);
    chk_rd(0, "rst_c",     4'hC, 32'h0);
    chk_irq(0, "rst_irq1", 8'h00);
    chk_irq(1, "rst_irq4", 8'h00);

    for (int i = 0; i < 26; i++) begin
      if (tv[i].w) wr(0, tv[i].a, tv[i].d);
      else         step();
      chk_rd(0, $sformatf("vec%0d_rd", i), tv[i].ra, tv[i].rexp);
      chk_irq(0, $sformatf("vec%0d_irq", i), tv[i].iexp);
    end

    wr(1, 4'h8, 32'd2);
    wr(1, 4'h0, 32'h1);
    repeat (3) step();
    chk_rd(1, "psc_pre_tick", 4'h4, 32'd0);
    step();
    chk_rd(1, "psc_tick1", 4'h4, 32'd1);
    repeat (3) step();
    chk_rd(1, "psc_no_pend", 4'h0, 32'h1);
    step();
    chk_rd(1, "psc_pend", 4'h0, 32'h5);
    chk_rd(1, "psc_wrap", 4'h4, 32'd0);
    chk_irq(1, "psc_ie0_irq", 8'h00);
    wr(1, 4'h0, 32'h3);
    chk_irq(1, "psc_ie1_irq", 8'h01);

    wr(0, 4'h0, 32'h4);
    wr(0, 4'h8, 32'h0);
    wr(0, 4'h4, 32'h0);
    wr(0, 4'h0, 32'h1);
    repeat (100) step();
    chk_rd(0, "v0_count", 4'h4, 32'h0);
    chk_rd(0, "v0_ctrl",  4'h0, 32'h1);

    wr(0, 4'h4, 32'hFFFF_FFFE);
    wr(0, 4'h8, 32'h1);
    chk_rd(0, "wrap_fe", 4'h4, 32'hFFFF_FFFE);
    step();
    chk_rd(0, "wrap_ff", 4'h4, 32'hFFFF_FFFF);
    step();
    chk_rd(0, "wrap_0",      4'h4, 32'h0);
    chk_rd(0, "wrap_nopend", 4'h0, 32'h1);
    step();
    chk_rd(0, "wrap_expire", 4'h0, 32'h5);
    wr(0, 4'h0, 32'h3);
    chk_irq(0, "wrap_irq", 8'h01);

    @(negedge clk);
    rst      = 1'b1;
    we[0]    = 1'b1;
    addr[0]  = 32'h1000_0004;
    wdata[0] = 32'h1234;
    @(posedge clk);
    #1;
    we[0] = 1'b0;
    rst   = 1'b0;
    chk_rd(0, "mid_rst_ctrl",  4'h0, 32'h0);
    chk_rd(0, "mid_rst_count", 4'h4, 32'h0);
    chk_rd(0, "mid_rst_value", 4'h8, 32'h0);
    chk_irq(0, "mid_rst_irq", 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
